bsg_test_node_packet_recorder: RTL and testbench

Capture stage between a test-node master's outbound channel and the MITM node's `from_master` input. It buffers packets the master emits, counts them against a programmed limit, and keeps a running checksum. It also exposes `done_o` so the testbench knows the master has produced its full response stream. Packets are forwarded unchanged downstream over a valid/yumi channel.

---
 rtl/bsg_fsb_pkg.sv | 13 +
 rtl/bsg_fifo_1r1w_small.sv | 49 ++++
 rtl/bsg_test_node_packet_recorder.sv | 117 +++++++++++
 tb/tb_bsg_test_node_packet_recorder.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bsg_fsb_pkg.sv
// Shared types for the FSB test-node packet recorder: recorder FSM encoding.
package bsg_fsb_pkg;

  localparam int unsigned recorder_state_width_lp = 2;

  typedef enum logic [recorder_state_width_lp-1:0] {
    e_rec_idle    = 2'd0,
    e_rec_capture = 2'd1,
    e_rec_drain   = 2'd2,
    e_rec_done    = 2'd3
  } bsg_test_node_recorder_state_e;

endpackage

// File: rtl/bsg_fifo_1r1w_small.sv
// Small circular FIFO with an asynchronous head read; data_o reads 0 while empty.
module bsg_fifo_1r1w_small #(
  parameter int ring_width_p = 8,
  parameter int els_p        = 4
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic                    v_i,
  input  logic [ring_width_p-1:0] data_i,
  input  logic                    yumi_i,
  output logic                    full_o,
  output logic                    empty_o,
  output logic                    last_o,
  output logic [ring_width_p-1:0] data_o
);

  localparam int ptr_width_lp = (els_p > 1) ? $clog2(els_p) : 1;

  logic [ring_width_p-1:0] mem_q [els_p];
  logic [ptr_width_lp-1:0] rptr_q, wptr_q;
  logic [ptr_width_lp:0]   cnt_q;

  // els_p is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rptr_q <= '0;
      wptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (v_i)    wptr_q <= wptr_q + ptr_width_lp'(1);
      if (yumi_i) rptr_q <= rptr_q + ptr_width_lp'(1);
      case ({v_i, yumi_i})
        2'b10:   cnt_q <= cnt_q + (ptr_width_lp+1)'(1);
        2'b01:   cnt_q <= cnt_q - (ptr_width_lp+1)'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (v_i) mem_q[wptr_q] <= data_i;
  end

  assign full_o  = (cnt_q == (ptr_width_lp+1)'(els_p));
  assign empty_o = (cnt_q == '0);
  assign last_o  = (cnt_q == (ptr_width_lp+1)'(1));
  assign data_o  = empty_o ? '0 : mem_q[rptr_q];

endmodule

// File: rtl/bsg_test_node_packet_recorder.sv
// Buffers, counts and checksums a test-node master's packets toward the MITM node.
// Checksum logic is built only when BSG_TEST_NODE_RECORDER_CHECKSUM_EN is defined.
module bsg_test_node_packet_recorder
  import bsg_fsb_pkg::*;
#(
  parameter int ring_width_p  = 8,
  parameter int els_p         = 4,
  parameter int count_width_p = 16
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     en_i,
  input  logic [count_width_p-1:0] limit_i,
  input  logic                     v_i,
  input  logic [ring_width_p-1:0]  data_i,
  output logic                     ready_o,
  output logic                     v_o,
  output logic [ring_width_p-1:0]  data_o,
  input  logic                     yumi_i,
  output logic [count_width_p-1:0] count_o,
  output logic [ring_width_p-1:0]  checksum_o,
  output logic                     done_o,
  output logic                     error_o
);

  bsg_test_node_recorder_state_e state_q, state_d;
  logic [count_width_p-1:0] limit_q, limit_d, count_q, count_d, count_inc;
  logic error_q, error_d;
  logic fifo_full, fifo_empty, fifo_last, accept;

  bsg_fifo_1r1w_small #(
    .ring_width_p(ring_width_p),
    .els_p       (els_p)
  ) fifo (
    .clk_i  (clk_i),
    .reset_i(reset_i),
    .v_i    (accept),
    .data_i (data_i),
    .yumi_i (yumi_i),
    .full_o (fifo_full),
    .empty_o(fifo_empty),
    .last_o (fifo_last),
    .data_o (data_o)
  );

  assign ready_o   = (state_q == e_rec_capture) && !fifo_full;
  assign accept    = v_i && ready_o;
  assign count_inc = (&count_q) ? count_q : count_q + count_width_p'(1);

  always_comb begin
    state_d = state_q;
    limit_d = limit_q;
    count_d = count_q;
    error_d = error_q;
    case (state_q)
      e_rec_idle: if (en_i) begin
        limit_d = limit_i;
        count_d = '0;
        error_d = 1'b0;
        state_d = (limit_i == '0) ? e_rec_drain : e_rec_capture;
      end
      e_rec_capture: begin
        if (accept) count_d = count_inc;
        if (!en_i || (accept && count_inc == limit_q)) state_d = e_rec_drain;
      end
      e_rec_drain: begin
        if (v_i) error_d = 1'b1;
        // Leave once the last buffered packet is consumed, not a cycle later.
        if (fifo_empty || (fifo_last && yumi_i)) state_d = e_rec_done;
      end
      e_rec_done: begin
        if (v_i) error_d = 1'b1;
        if (!en_i) state_d = e_rec_idle;
      end
      default: state_d = e_rec_idle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= e_rec_idle;
      limit_q <= '0;
      count_q <= '0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      limit_q <= limit_d;
      count_q <= count_d;
      error_q <= error_d;
    end
  end

`ifdef BSG_TEST_NODE_RECORDER_CHECKSUM_EN
  logic [ring_width_p-1:0] checksum_q, checksum_d;

  always_comb begin
    checksum_d = checksum_q;
    if (state_q == e_rec_idle && en_i) checksum_d = '0;
    else if (accept)                   checksum_d = checksum_q + data_i;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) checksum_q <= '0;
    else         checksum_q <= checksum_d;
  end

  assign checksum_o = checksum_q;
`else
  assign checksum_o = '0;
`endif

  assign v_o     = !fifo_empty;
  assign count_o = count_q;
  assign done_o  = (state_q == e_rec_done);
  assign error_o = error_q;

endmodule

// File: tb/tb_bsg_test_node_packet_recorder.sv
// Directed and randomized bench for bsg_test_node_packet_recorder against a queue-based model.
module tb_bsg_test_node_packet_recorder;

  localparam int W   = 8;
  localparam int ELS = 4;
  localparam int CW  = 16;

  logic clk = 1'b0;
  logic reset_i, en_i, v_i, yumi_en, yumi_i;
  logic [CW-1:0] limit_i, count_o;
  logic [W-1:0]  data_i, data_o, checksum_o;
  logic ready_o, v_o, done_o, error_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Downstream consumer only ever yumis a visible head.
  assign yumi_i = yumi_en & v_o;

  bsg_test_node_packet_recorder #(
    .ring_width_p (W),
    .els_p        (ELS),
    .count_width_p(CW)
  ) dut (
    .clk_i     (clk),
    .reset_i   (reset_i),
    .en_i      (en_i),
    .limit_i   (limit_i),
    .v_i       (v_i),
    .data_i    (data_i),
    .ready_o   (ready_o),
    .v_o       (v_o),
    .data_o    (data_o),
    .yumi_i    (yumi_i),
    .count_o   (count_o),
    .checksum_o(checksum_o),
    .done_o    (done_o),
    .error_o   (error_o)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h time=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: run phase, packet queue, counters.
  typedef enum int {M_IDLE, M_CAP, M_DRAIN, M_DONE} mphase_t;
  mphase_t      m_phase;
  logic [W-1:0] m_q[$];
  int           m_cnt, m_lim;
  logic [W-1:0] m_sum;
  bit           m_err;
  bit           m_live = 1'b0;
  bit           m_acc;
  logic [W-1:0] m_junk;

  always @(posedge clk) begin
    if (reset_i) begin
      m_phase = M_IDLE;
      m_q.delete();
      m_cnt = 0; m_lim = 0; m_sum = '0; m_err = 1'b0;
      m_live = 1'b1;
    end else if (m_live) begin
      m_acc = v_i && (m_phase == M_CAP) && (m_q.size() < ELS);
      if (yumi_i) begin
        chk("yumi_has_packet", 32'(m_q.size() != 0), 32'd1);
        if (m_q.size() != 0) m_junk = m_q.pop_front();
      end
      case (m_phase)
        M_IDLE: if (en_i) begin
          m_lim = int'(limit_i);
          m_cnt = 0; m_sum = '0; m_err = 1'b0;
          m_phase = (limit_i == '0) ? M_DRAIN : M_CAP;
        end
        M_CAP: begin
          if (m_acc) begin
            m_q.push_back(data_i);
            if (m_cnt < (1 << CW) - 1) m_cnt++;
            m_sum = m_sum + data_i;
          end
          if (!en_i || (m_acc && m_cnt == m_lim)) m_phase = M_DRAIN;
        end
        M_DRAIN: begin
          if (v_i) m_err = 1'b1;
          if (m_q.size() == 0) m_phase = M_DONE;
        end
        M_DONE: begin
          if (v_i) m_err = 1'b1;
          if (!en_i) m_phase = M_IDLE;
        end
        default: m_phase = M_IDLE;
      endcase
    end
  end

  always @(negedge clk) begin
    if (m_live) begin
      chk("ready_o", 32'(ready_o), 32'((m_phase == M_CAP) && (m_q.size() < ELS)));
      chk("v_o", 32'(v_o), 32'(m_q.size() != 0));
      chk("data_o", 32'(data_o), (m_q.size() != 0) ? 32'(m_q[0]) : 32'd0);
      chk("count_o", 32'(count_o), 32'(m_cnt));
`ifdef BSG_TEST_NODE_RECORDER_CHECKSUM_EN
      chk("checksum_o", 32'(checksum_o), 32'(m_sum));
`else
      chk("checksum_o", 32'(checksum_o), 32'd0);
`endif
      chk("done_o", 32'(done_o), 32'(m_phase == M_DONE));
      chk("error_o", 32'(error_o), 32'(m_err));
    end
  end

  always @(posedge clk) begin
    if (yumi_i && !v_o) $error("yumi_i asserted with v_o low");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (!done_o && n < budget) begin
      tick();
      n++;
    end
    chk("done_reached", 32'(done_o), 32'd1);
  endtask

  logic [31:0] sum_exp_66, sum_exp_10;

  initial begin
`ifdef BSG_TEST_NODE_RECORDER_CHECKSUM_EN
    sum_exp_66 = 32'h66; sum_exp_10 = 32'h10;
`else
    sum_exp_66 = 32'h0;  sum_exp_10 = 32'h0;
`endif
    reset_i = 1'b1; en_i = 1'b0; v_i = 1'b0; yumi_en = 1'b0;
    limit_i = '0; data_i = '0;
    tick(); tick();
    reset_i = 1'b0;
    chk("rst_ready", 32'(ready_o), 0);
    chk("rst_v", 32'(v_o), 0);
    chk("rst_data", 32'(data_o), 0);
    chk("rst_count", 32'(count_o), 0);
    chk("rst_sum", 32'(checksum_o), 0);
    chk("rst_done", 32'(done_o), 0);
    chk("rst_error", 32'(error_o), 0);

    // Three packets back to back, consumer always ready.
    limit_i = 16'd3; en_i = 1'b1; yumi_en = 1'b1; tick();
    chk("t1_ready", 32'(ready_o), 1);
    v_i = 1'b1; data_i = 8'h11; tick();
    chk("t1_head0", 32'(data_o), 32'h11);
    data_i = 8'h22; tick();
    chk("t1_head1", 32'(data_o), 32'h22);
    data_i = 8'h33; tick();
    chk("t1_head2", 32'(data_o), 32'h33);
    v_i = 1'b0; tick();
    chk("t1_count", 32'(count_o), 3);
    chk("t1_sum", 32'(checksum_o), sum_exp_66);
    chk("t1_done", 32'(done_o), 1);
    chk("t1_error", 32'(error_o), 0);
    en_i = 1'b0; tick();

    // Backpressure: fill the FIFO, then free one slot.
    limit_i = 16'd8; en_i = 1'b1; yumi_en = 1'b0; tick();
    v_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      data_i = W'($urandom); tick();
    end
    chk("t2_full_ready", 32'(ready_o), 0);
    chk("t2_count4", 32'(count_o), 4);
    yumi_en = 1'b1; tick(); yumi_en = 1'b0;
    chk("t2_ready_back", 32'(ready_o), 1);
    data_i = W'($urandom); tick();
    chk("t2_count5", 32'(count_o), 5);
    yumi_en = 1'b1;
    for (int n = 0; n < 50 && count_o != 16'd8; n++) begin
      data_i = W'($urandom); tick();
    end
    chk("t2_count8", 32'(count_o), 8);
    v_i = 1'b0;
    wait_done(20);
    chk("t2_error", 32'(error_o), 0);
    en_i = 1'b0; tick();

    // Extra packet offered past the limit.
    limit_i = 16'd2; en_i = 1'b1; yumi_en = 1'b1; tick();
    v_i = 1'b1; data_i = 8'h5A; tick();
    data_i = 8'hA5; tick();
    data_i = 8'hC3;
    chk("t3_ready", 32'(ready_o), 0);
    tick();
    chk("t3_error", 32'(error_o), 1);
    chk("t3_count", 32'(count_o), 2);
    wait_done(20);
    chk("t3_no_extra", 32'(v_o), 0);
    v_i = 1'b0; tick();
    chk("t3_error_sticky", 32'(error_o), 1);
    en_i = 1'b0; tick();

    // Early stop via en_i, then a fresh run clears the count.
    limit_i = 16'd10; en_i = 1'b1; yumi_en = 1'b1; tick();
    v_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      data_i = W'($urandom); tick();
    end
    chk("t4_count4", 32'(count_o), 4);
    en_i = 1'b0; v_i = 1'b0; tick();
    chk("t4_drain_ready", 32'(ready_o), 0);
    wait_done(20);
    chk("t4_done_count", 32'(count_o), 4);
    tick();
    chk("t4_idle", 32'(done_o), 0);
    limit_i = 16'd1; en_i = 1'b1; tick();
    chk("t4_cleared", 32'(count_o), 0);

    // limit 1: DONE the cycle after the yumi.
    v_i = 1'b1; data_i = 8'h77; tick();
    v_i = 1'b0;
    chk("t5_ready", 32'(ready_o), 0);
    chk("t5_v", 32'(v_o), 1);
    chk("t5_not_done", 32'(done_o), 0);
    tick();
    chk("t5_done", 32'(done_o), 1);
    en_i = 1'b0; tick();

    // Reset with two packets buffered.
    limit_i = 16'd8; en_i = 1'b1; yumi_en = 1'b0; tick();
    v_i = 1'b1; data_i = W'($urandom); tick();
    data_i = W'($urandom); tick();
    v_i = 1'b0;
    chk("t6_buffered", 32'(count_o), 2);
    reset_i = 1'b1; en_i = 1'b0; tick();
    reset_i = 1'b0;
    chk("t6_v", 32'(v_o), 0);
    chk("t6_ready", 32'(ready_o), 0);
    chk("t6_count", 32'(count_o), 0);
    chk("t6_done", 32'(done_o), 0);

    // Checksum wraps modulo 2^8.
    limit_i = 16'd2; en_i = 1'b1; yumi_en = 1'b1; tick();
    v_i = 1'b1; data_i = 8'hF0; tick();
    data_i = 8'h20; tick();
    v_i = 1'b0;
    wait_done(20);
    chk("t7_sum_wrap", 32'(checksum_o), sum_exp_10);
    en_i = 1'b0; tick();

    // Randomized runs.
    for (int r = 0; r < 25; r++) begin
      limit_i = CW'($urandom_range(0, 12));
      en_i = 1'b1; tick();
      for (int c = 0; c < 150 && !done_o; c++) begin
        v_i     = 1'($urandom_range(0, 1));
        data_i  = W'($urandom);
        yumi_en = ($urandom_range(0, 3) != 0);
        if ($urandom_range(0, 40) == 0) en_i = 1'b0;
        tick();
      end
      v_i = 1'b0; yumi_en = 1'b1; en_i = 1'b0;
      wait_done(50);
      tick();
    end

    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
